// File: rtl/frogger_lane_scheduler_pkg.sv
// Shared types and sprite geometry for the Frogger per-frame lane scheduler.
package frogger_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    HIT     = 2'd2,
    TIMEOUT = 2'd3
  } game_state_t;

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_FT    = 3'd1,
    S_BUS   = 3'd2,
    S_MC    = 3'd3,
    S_TIMER = 3'd4,
    S_COLL  = 3'd5
  } seq_state_t;

  localparam int FROG_W = 17;
  localparam int FROG_H = 16;
  localparam int FT_W   = 25;
  localparam int FT_H   = 16;
  localparam int BUS_W  = 19;
  localparam int BUS_H  = 14;
  localparam int MC_W   = 16;
  localparam int MC_H   = 23;

  // Half-open interval intersection: [a, a+a_len) vs [b, b+b_len).
  function automatic logic spans_overlap(logic [10:0] a, logic [10:0] a_len,
                                         logic [10:0] b, logic [10:0] b_len);
    return (a < b + b_len) && (b < a + a_len);
  endfunction

endpackage

// File: rtl/frogger_lane_scheduler_if.sv
// Frame control, frog position and playfield outputs of the lane scheduler.
interface frogger_lane_scheduler_if;
  import frogger_pkg::*;

  logic        frame_start;
  logic        start_game;
  logic [9:0]  frog_x;
  logic [9:0]  frog_y;
  logic [9:0]  firetruck_x;
  logic [9:0]  bus_x;
  logic [9:0]  motorcycle_x;
  logic [9:0]  time_width;
  game_state_t game_state;
  logic        frog_hit;
  logic        busy;

  modport slave (
    input  frame_start, start_game, frog_x, frog_y,
    output firetruck_x, bus_x, motorcycle_x, time_width, game_state, frog_hit, busy
  );

  modport master (
    output frame_start, start_game, frog_x, frog_y,
    input  firetruck_x, bus_x, motorcycle_x, time_width, game_state, frog_hit, busy
  );

endinterface

// File: rtl/frogger_lane_step.sv
// Combinational one-frame move of a lane X position with horizontal wrap.
module frogger_lane_step #(
  parameter int SCREEN_W = 640
) (
  input  logic [9:0] x,
  input  logic [9:0] speed,
  input  logic       dir,
  output logic [9:0] x_next
);

  logic [10:0] sum;
  logic [10:0] left_wrap;

  assign sum       = {1'b0, x} + {1'b0, speed};
  assign left_wrap = {1'b0, x} + 11'(SCREEN_W) - {1'b0, speed};

  // dir = 1 moves right, dir = 0 moves left; speed is always below SCREEN_W.
  always_comb begin
    if (dir) begin
      x_next = (sum >= 11'(SCREEN_W)) ? 10'(sum - 11'(SCREEN_W)) : sum[9:0];
    end else begin
      x_next = (x < speed) ? left_wrap[9:0] : x - speed;
    end
  end

endmodule

// File: rtl/frogger_lane_scheduler.sv
// Per-frame sequencer: moves three lanes through one shared step datapath,
// ticks the time bar, checks frog collision and runs the game-state machine.
module frogger_lane_scheduler
  import frogger_pkg::*;
#(
  parameter int SCREEN_W        = 640,
  parameter int TIME_INIT       = 200,
  parameter int TIME_STEP       = 1,
  parameter int FRAMES_PER_TICK = 30,
  parameter int X_INIT          = 440,
  parameter int FT_SPEED        = 2,
  parameter int BUS_SPEED       = 3,
  parameter int MC_SPEED        = 5,
  parameter bit FT_DIR          = 1'b0,
  parameter bit BUS_DIR         = 1'b1,
  parameter bit MC_DIR          = 1'b0,
  parameter int FT_Y            = 290,
  parameter int BUS_Y           = 330,
  parameter int MC_Y            = 360
) (
  input logic                     Clk,
  input logic                     Reset_n,
  frogger_lane_scheduler_if.slave lane_if
);

  localparam int CNT_W = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;

  seq_state_t       state_q, state_d;
  game_state_t      game_q;
  logic [9:0]       ft_x_q, bus_x_q, mc_x_q, time_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hit_q;

  logic [9:0]       step_x, step_speed, step_x_next;
  logic             step_dir;
  logic             restart;
  logic             hit;

  // A new game may only be requested outside PLAY; it wins over frame_start.
  assign restart = lane_if.start_game && (game_q != PLAY);

  // NOTE: non-blocking assignments make every register see pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_WAIT;
    else          state_q <= state_d;
  end

  // NOTE: defaults first so no path through the block leaves a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT: begin
        if (!restart && lane_if.frame_start && (game_q == PLAY)) state_d = S_FT;
      end
      S_FT:    state_d = S_BUS;
      S_BUS:   state_d = S_MC;
      S_MC:    state_d = S_TIMER;
      S_TIMER: state_d = S_COLL;
      default: state_d = S_WAIT;
    endcase
  end

  always_comb begin
    step_x     = ft_x_q;
    step_speed = 10'(FT_SPEED);
    step_dir   = FT_DIR;
    case (state_q)
      S_BUS: begin
        step_x     = bus_x_q;
        step_speed = 10'(BUS_SPEED);
        step_dir   = BUS_DIR;
      end
      S_MC: begin
        step_x     = mc_x_q;
        step_speed = 10'(MC_SPEED);
        step_dir   = MC_DIR;
      end
      default: ;
    endcase
  end

  frogger_lane_step #(.SCREEN_W(SCREEN_W)) u_step (
    .x      (step_x),
    .speed  (step_speed),
    .dir    (step_dir),
    .x_next (step_x_next)
  );

  // Evaluated in S_COLL, after all three lanes hold this frame's positions.
  assign hit =
      (spans_overlap({1'b0, lane_if.frog_x}, 11'(FROG_W), {1'b0, ft_x_q}, 11'(FT_W)) &&
       spans_overlap({1'b0, lane_if.frog_y}, 11'(FROG_H), 11'(FT_Y), 11'(FT_H))) ||
      (spans_overlap({1'b0, lane_if.frog_x}, 11'(FROG_W), {1'b0, bus_x_q}, 11'(BUS_W)) &&
       spans_overlap({1'b0, lane_if.frog_y}, 11'(FROG_H), 11'(BUS_Y), 11'(BUS_H))) ||
      (spans_overlap({1'b0, lane_if.frog_x}, 11'(FROG_W), {1'b0, mc_x_q}, 11'(MC_W)) &&
       spans_overlap({1'b0, lane_if.frog_y}, 11'(FROG_H), 11'(MC_Y), 11'(MC_H)));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ft_x_q  <= 10'(X_INIT);
      bus_x_q <= 10'(X_INIT);
      mc_x_q  <= 10'(X_INIT);
      time_q  <= 10'(TIME_INIT);
      cnt_q   <= '0;
      game_q  <= IDLE;
      hit_q   <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      case (state_q)
        S_WAIT: begin
          if (restart) begin
            ft_x_q  <= 10'(X_INIT);
            bus_x_q <= 10'(X_INIT);
            mc_x_q  <= 10'(X_INIT);
            time_q  <= 10'(TIME_INIT);
            cnt_q   <= '0;
            game_q  <= PLAY;
          end
        end
        S_FT:  ft_x_q  <= step_x_next;
        S_BUS: bus_x_q <= step_x_next;
        S_MC:  mc_x_q  <= step_x_next;
        S_TIMER: begin
          if (cnt_q == CNT_W'(FRAMES_PER_TICK - 1)) begin
            cnt_q  <= '0;
            time_q <= (time_q <= 10'(TIME_STEP)) ? '0 : time_q - 10'(TIME_STEP);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_COLL: begin
          if (hit) begin
            hit_q  <= 1'b1;
            game_q <= HIT;
          end else if (time_q == '0) begin
            game_q <= TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  assign lane_if.firetruck_x  = ft_x_q;
  assign lane_if.bus_x        = bus_x_q;
  assign lane_if.motorcycle_x = mc_x_q;
  assign lane_if.time_width   = time_q;
  assign lane_if.game_state   = game_q;
  assign lane_if.frog_hit     = hit_q;
  assign lane_if.busy         = (state_q != S_WAIT);

endmodule
